// File: rtl/icache_direct_if.sv
// Fetch-side and memory-side signals of icache_direct.
// slave: the cache; master: the fetch stage plus the memory controller.
interface icache_direct_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        flush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, flush, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, flush, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache, one word per frame.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_direct #(
  parameter int unsigned SETS = 16
) (
  input  logic CLK,
  input  logic nRST,
`ifdef ICACHE_STATS_EN
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
`endif
  icache_direct_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            state, state_n;
  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [31:0]       data_q [SETS];
  logic [31:0]       miss_addr;

  logic [IDX_W-1:0]  req_idx, fill_idx;
  logic [TAG_W-1:0]  req_tag, fill_tag;
  logic              lookup_hit;
  logic              hit_c, miss_start, fill_en, iren_c;
  logic [31:0]       iaddr_c, load_c;
  logic              unused_byte_offset;

  assign req_idx            = bus.imemaddr[IDX_W+1:2];
  assign req_tag            = bus.imemaddr[31:IDX_W+2];
  assign fill_idx           = miss_addr[IDX_W+1:2];
  assign fill_tag           = miss_addr[31:IDX_W+2];
  assign unused_byte_offset = ^bus.imemaddr[1:0];

  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_n;
  end

  // Next state, lookup and memory request; flush outranks hit, miss and fill
  always_comb begin
    state_n    = state;
    hit_c      = 1'b0;
    miss_start = 1'b0;
    fill_en    = 1'b0;
    iren_c     = 1'b0;
    iaddr_c    = 32'h0;
    case (state)
      IDLE: begin
        hit_c      = bus.imemREN && lookup_hit && !bus.flush;
        miss_start = bus.imemREN && !lookup_hit && !bus.flush;
        if (miss_start) state_n = FETCH;
      end
      FETCH: begin
        iren_c  = 1'b1;
        iaddr_c = miss_addr;
        if (bus.flush) begin
          state_n = IDLE;
        end else if (!bus.iwait) begin
          fill_en = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign load_c = hit_c ? data_q[req_idx] : 32'h0;

  assign bus.ihit     = hit_c;
  assign bus.imemload = load_c;
  assign bus.iREN     = iren_c;
  assign bus.iaddr    = iaddr_c;

  // Word-aligned miss address, held for the whole fetch
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)           miss_addr <= 32'h0;
    else if (miss_start) miss_addr <= {bus.imemaddr[31:2], 2'b00};
  end

  // Frame storage; a fill overwrites its frame unconditionally
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      for (int i = 0; i < int'(SETS); i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= 32'h0;
      end
    end else if (bus.flush) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
      tag_q[fill_idx]   <= fill_tag;
      data_q[fill_idx]  <= bus.iload;
    end
  end

`ifdef ICACHE_STATS_EN
  // Free-running statistics, cleared only by reset
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else begin
      hit_count  <= hit_count + 32'(hit_c);
      miss_count <= miss_count + 32'(miss_start);
    end
  end
`endif

endmodule
